// File: rtl/hdmi_info_frame_pkg.sv
// Shared types and constants for the HDMI InfoFrame packet sources.
package hdmi_info_frame_pkg;

  localparam logic [6:0] VENDOR = 7'd1;
  localparam logic [6:0] AVI    = 7'd2;
  localparam logic [6:0] SPD    = 7'd3;
  localparam logic [6:0] AUDIO  = 7'd4;

  localparam int unsigned PB_COUNT     = 28;
  localparam logic [4:0]  PB_LAST      = 5'(PB_COUNT - 1);
  localparam logic [4:0]  LAST_SUM_IDX = 5'd29;

  // PB0 (checksum) through PB27
  typedef logic [PB_COUNT-1:0][7:0] pb_array_t;

  typedef enum logic [1:0] {IDLE, SUM, PENDING} state_e;

endpackage

// File: rtl/info_frame_checksum.sv
// Serial 8-bit wrapping accumulator; checksum makes the byte total (incl. current byte) zero.
module info_frame_checksum (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] data,
  output logic [7:0] checksum
);

  logic [7:0] acc_q, acc_d;
  logic [7:0] sum_now;

  always_comb begin
    sum_now  = acc_q + (add_en ? data : 8'h00);
    acc_d    = clear ? 8'h00 : sum_now;
    checksum = 8'h00 - sum_now;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/info_frame_builder.sv
// Runtime-programmable InfoFrame source: shadow payload, serial checksum, tear-free swap to
// the active packet on a frame boundary.
module info_frame_builder
  import hdmi_info_frame_pkg::*;
#(
  parameter logic [6:0] INFO_TYPE     = AVI,
  parameter logic [7:0] INFO_VERSION  = 8'd2,
  parameter logic [4:0] MAX_LENGTH    = 5'd27,
  parameter bit         SYNC_TO_FRAME = 1'b1
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [4:0]       length,
  input  logic             commit,
  input  logic             frame_boundary,
  output logic             busy,
  output logic             valid,
  output logic             wr_reject,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub
);

  state_e     state_q, state_d;
  pb_array_t  shadow_q, snap_q, active_q;
  logic [4:0] shadow_len_q, idx_q;
  logic [23:0] header_q;
  logic       valid_q, reject_q;

  logic       start, sum_en, swap, wr_accept;
  logic [4:0] commit_len;
  logic [7:0] sum_byte, checksum;

  assign commit_len = (length > MAX_LENGTH) ? MAX_LENGTH : length;
  assign wr_accept  = (state_q == IDLE) && wr_en && (wr_addr != 5'd0) && (wr_addr <= PB_LAST);

  // FSM: state register
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = SUM;
      SUM:     if (idx_q == LAST_SUM_IDX) state_d = PENDING;
      PENDING: if (!SYNC_TO_FRAME || frame_boundary) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_q != IDLE);
    start  = (state_q == IDLE) && commit;
    sum_en = (state_q == SUM);
    swap   = (state_q == PENDING) && (!SYNC_TO_FRAME || frame_boundary);
  end

  // Walk order: HB0, HB1, HB2, then PB1..PB27 from the masked snapshot
  always_comb begin
    sum_byte = 8'h00;
    case (idx_q)
      5'd0:    sum_byte = {1'b1, INFO_TYPE};
      5'd1:    sum_byte = INFO_VERSION;
      5'd2:    sum_byte = {3'b000, shadow_len_q};
      default: if (idx_q <= LAST_SUM_IDX) sum_byte = snap_q[idx_q - 5'd2];
    endcase
  end

  info_frame_checksum u_checksum (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .clear     (start),
    .add_en    (sum_en),
    .data      (sum_byte),
    .checksum  (checksum)
  );

  // Snapshot at commit so a same-cycle write cannot tear the packet being summed
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q     <= '0;
      snap_q       <= '0;
      active_q     <= '0;
      shadow_len_q <= 5'd0;
      idx_q        <= 5'd0;
      header_q     <= 24'h0;
      valid_q      <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      reject_q <= busy && (wr_en || commit);
      if (wr_accept) shadow_q[wr_addr] <= wr_data;
      if (start) begin
        shadow_len_q <= commit_len;
        idx_q        <= 5'd0;
        for (int i = 1; i < PB_COUNT; i++) begin
          snap_q[i] <= (5'(i) <= commit_len) ? shadow_q[i] : 8'h00;
        end
      end
      if (sum_en) begin
        idx_q <= idx_q + 5'd1;
        if (idx_q == LAST_SUM_IDX) snap_q[0] <= checksum;
      end
      if (swap) begin
        active_q <= snap_q;
        header_q <= {3'b000, shadow_len_q, INFO_VERSION, 1'b1, INFO_TYPE};
        valid_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    sub = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 7; j++) begin
        sub[i][8*j +: 8] = active_q[7*i + j];
      end
    end
  end

  assign header    = header_q;
  assign valid     = valid_q;
  assign wr_reject = reject_q;

endmodule

// File: tb/tb_info_frame_builder.sv
// Directed bench for info_frame_builder: two parameterisations, scoreboard of expected packets.
module tb_info_frame_builder;

  typedef struct {
    logic [23:0]      hdr;
    logic [3:0][55:0] sb;
  } pkt_t;

  logic             clk = 1'b0;
  logic [1:0]       rst_n, wr_en, commit, fb, busy, valid, wr_reject;
  logic [4:0]       wr_addr [2];
  logic [7:0]       wr_data [2];
  logic [4:0]       length  [2];
  logic [23:0]      header  [2];
  logic [3:0][55:0] sub     [2];

  int   ty   [2] = '{2, 1};
  int   ver  [2] = '{2, 1};
  int   maxl [2] = '{27, 25};
  logic [7:0] sh [2][28];
  pkt_t q0[$], q1[$];
  pkt_t cur [2];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  info_frame_builder #(
    .INFO_TYPE(7'd2), .INFO_VERSION(8'd2), .MAX_LENGTH(5'd27), .SYNC_TO_FRAME(1'b0)
  ) dut0 (
    .clk_pixel(clk), .reset_n(rst_n[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .length(length[0]), .commit(commit[0]), .frame_boundary(fb[0]),
    .busy(busy[0]), .valid(valid[0]), .wr_reject(wr_reject[0]), .header(header[0]),
    .sub(sub[0])
  );

  info_frame_builder #(
    .INFO_TYPE(7'd1), .INFO_VERSION(8'd1), .MAX_LENGTH(5'd25), .SYNC_TO_FRAME(1'b1)
  ) dut1 (
    .clk_pixel(clk), .reset_n(rst_n[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .length(length[1]), .commit(commit[1]), .frame_boundary(fb[1]),
    .busy(busy[1]), .valid(valid[1]), .wr_reject(wr_reject[1]), .header(header[1]),
    .sub(sub[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t model(input int d, input logic [4:0] len_in);
    pkt_t p;
    int len;
    logic [7:0] b [28];
    logic [7:0] sum;
    len = (int'(len_in) > maxl[d]) ? maxl[d] : int'(len_in);
    sum = {1'b1, 7'(ty[d])} + 8'(ver[d]) + 8'(len);
    for (int i = 1; i < 28; i++) begin
      b[i] = (i <= len) ? sh[d][i] : 8'h00;
      sum  = sum + b[i];
    end
    b[0]  = 8'h00 - sum;
    p.hdr = {3'b000, 5'(len), 8'(ver[d]), 1'b1, 7'(ty[d])};
    p.sb  = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 7; j++) p.sb[i][8*j +: 8] = b[7*i + j];
    return p;
  endfunction

  task automatic wr(input int d, input int a, input logic [7:0] v);
    wr_en[d] = 1'b1; wr_addr[d] = 5'(a); wr_data[d] = v;
    step();
    wr_en[d] = 1'b0;
    if (a >= 1 && a <= 27) sh[d][a] = v;
  endtask

  task automatic do_commit(input int d, input logic [4:0] len);
    length[d] = len; commit[d] = 1'b1;
    if (d == 0) q0.push_back(model(d, len)); else q1.push_back(model(d, len));
    step();
    commit[d] = 1'b0;
  endtask

  task automatic pop_check(input int d, input string tag);
    pkt_t p;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    p = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk({tag, "_header"}, header[d], p.hdr);
    chk({tag, "_sub"}, sub[d], p.sb);
    chk({tag, "_valid"}, valid[d], 1'b1);
    cur[d] = p;
  endtask

  task automatic wait_swap(input int d, input string tag, output int n);
    n = 0;
    fb[d] = (d == 1);
    while (busy[d] === 1'b1 && n < 100) begin
      step();
      n++;
    end
    fb[d] = 1'b0;
    chk({tag, "_busy_done"}, busy[d], 1'b0);
    pop_check(d, tag);
  endtask

  initial begin
    int n;
    rst_n = 2'b00; wr_en = '0; commit = '0; fb = '0;
    for (int d = 0; d < 2; d++) begin
      wr_addr[d] = '0; wr_data[d] = '0; length[d] = '0;
      cur[d].hdr = '0; cur[d].sb = '0;
      for (int i = 0; i < 28; i++) sh[d][i] = 8'h00;
    end
    step(); step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", valid[d], 1'b0);
      chk("rst_busy", busy[d], 1'b0);
      chk("rst_reject", wr_reject[d], 1'b0);
      chk("rst_header", header[d], 24'h0);
      chk("rst_sub", sub[d], '0);
    end
    rst_n = 2'b11;
    step();

    // AVI-style packet, unsynchronised swap, fixed latency
    wr(0, 4, 8'h10);
    do_commit(0, 5'd13);
    wait_swap(0, "t1", n);
    chk("t1_latency", n, 31);
    chk("t1_header_const", header[0], 24'h0D0282);
    chk("t1_pb0_const", sub[0][0][7:0], 8'h5F);

    // Out-of-range addresses are silently ignored
    wr(0, 0, 8'h55);
    chk("bad_addr0_noreject", wr_reject[0], 1'b0);
    wr(0, 30, 8'h77);
    chk("bad_addr30_noreject", wr_reject[0], 1'b0);

    // Busy-time writes and commits bounce, active packet holds
    for (int i = 1; i <= 13; i++) wr(0, i, 8'(i * 7 + 3));
    do_commit(0, 5'd13);
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 8'hAA;
    step();
    wr_en[0] = 1'b0;
    chk("t4_wr_reject", wr_reject[0], 1'b1);
    step();
    chk("t4_reject_clear", wr_reject[0], 1'b0);
    commit[0] = 1'b1; length[0] = 5'd2;
    step();
    commit[0] = 1'b0;
    chk("t4_commit_reject", wr_reject[0], 1'b1);
    step();
    chk("t4_reject_clear2", wr_reject[0], 1'b0);
    chk("t4_active_hold", header[0], cur[0].hdr);
    chk("t4_sub_hold", sub[0], cur[0].sb);
    wait_swap(0, "t4", n);

    // Same-cycle write and commit: old byte summed, new byte kept for next commit
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 8'h99;
    length[0] = 5'd13; commit[0] = 1'b1;
    q0.push_back(model(0, 5'd13));
    sh[0][4] = 8'h99;
    step();
    wr_en[0] = 1'b0; commit[0] = 1'b0;
    wait_swap(0, "same_cycle", n);
    do_commit(0, 5'd13);
    wait_swap(0, "same_cycle_next", n);

    // Vendor-type packet with zero length: all payload masked
    for (int i = 1; i <= 27; i++) wr(1, i, 8'hFF);
    do_commit(1, 5'd0);
    wait_swap(1, "t2", n);
    chk("t2_header_const", header[1], 24'h000181);
    chk("t2_pb0_const", sub[1][0][7:0], 8'h7E);

    // Frame-synchronised swap: boundary during SUM (incl. its last cycle) ignored
    do_commit(1, 5'd10);
    for (int i = 1; i <= 40; i++) begin
      fb[1] = (i == 10 || i == 30 || i == 40);
      step();
      fb[1] = 1'b0;
      if (i < 40) begin
        chk("t3_busy_held", busy[1], 1'b1);
        chk("t3_header_held", header[1], cur[1].hdr);
        chk("t3_sub_held", sub[1], cur[1].sb);
      end
    end
    chk("t3_busy_low", busy[1], 1'b0);
    pop_check(1, "t3");

    // Length clamps to MAX_LENGTH=25
    for (int i = 1; i <= 27; i++) wr(1, i, 8'(i * 3 + 1));
    do_commit(1, 5'd31);
    wait_swap(1, "t5", n);
    chk("t5_len", header[1][20:16], 5'd25);
    chk("t5_pb26_27", sub[1][3][55:40], 16'h0);

    // Reset mid-SUM abandons the commit
    do_commit(0, 5'd13);
    repeat (5) step();
    rst_n[0] = 1'b0;
    #1;
    chk("t6_valid", valid[0], 1'b0);
    chk("t6_busy", busy[0], 1'b0);
    chk("t6_header", header[0], 24'h0);
    chk("t6_sub", sub[0], '0);
    q0.delete();
    for (int i = 0; i < 28; i++) sh[0][i] = 8'h00;
    step();
    rst_n[0] = 1'b1;
    step();
    wr(0, 2, 8'h21);
    wr(0, 13, 8'h5A);
    do_commit(0, 5'd13);
    wait_swap(0, "t6_fresh", n);
    chk("t6_latency", n, 31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
